mac_tile_scheduler: RTL and testbench
=====================================

Name: mac_tile_scheduler

Overview:
- Control unit that sequences the 4x4 MAC array datapath for an output matrix O[t][m] = sum over n of I[t][n] * W[m][n].
- Latches M, N and T at START. Walks the output in 4x4 tiles, with tb (T-block) as the outer loop and mb (M-block) as the inner loop.
- Per tile it issues input and weight memory reads, drives accumulate steps, then writes result rows to output memory.
- Sits between the top-level handshake (START/MNT) and the MAC datapath plus the three SRAMs.

Parameters:
- TILE, 4, array edge (rows and columns per tile).
- MAXDIM, 8, largest legal M, N or T.
- RD_LAT, 1, SRAM read latency in cycles; fixed, no other value supported.

Ports:
- CLK  in  1  clock
- RSTN  in  1  asynchronous active-low reset
- START  in  1  1-cycle request, sampled only in IDLE
- MNT  in  12  M=[11:8], N=[7:4], T=[3:0]
- BUSY  out  1  high from the cycle after an accepted START until DONE
- DONE  out  1  1-cycle completion pulse
- ERR  out  1  pulses together with DONE when the MNT value is illegal
- EN_I  out  1  input SRAM read enable
- ADDR_I  out  3  input row address (t)
- EN_W  out  1  weight SRAM read enable
- ADDR_W  out  3  weight row address (m)
- EN_O  out  1  output SRAM enable
- RW_O  out  1  1 = write
- ADDR_O  out  4  {t[2:0], mb}
- DP_CLR  out  1  clear all 16 accumulators
- DP_LD  out  1  capture RDATA_I/RDATA_W into row DP_LD_ROW
- DP_LD_ROW  out  2  row being loaded
- DP_ZI  out  1  with DP_LD: load zeros instead of RDATA_I
- DP_ZW  out  1  with DP_LD: load zeros instead of RDATA_W
- DP_ACC_EN  out  1  one MAC step
- DP_K  out  3  reduction index n for this step
- DP_COL_MASK  out  4  bit c=1 if mb*4+c < M; masked columns drive 0 on WDATA_O
- DP_OSEL  out  2  accumulator row that drives WDATA_O

Behaviour:
- Reset (asynchronous, mid-operation included): state=IDLE, all counters 0, every output 0. In-flight work is abandoned and no write completes after RSTN falls.
- Legality: M, N and T must each be in 1..8. If any is illegal, the block goes IDLE->DONE, pulses DONE and ERR, and issues no memory access.
- Tile counts: nt = ceil(T/4), nm = ceil(M/4), each 1 or 2.
- START while BUSY is ignored. MNT is used only as latched at START.
- LOAD state, 5 cycles, local counter c = 0..4:
  - Cycle 0: DP_CLR = 1.
  - Cycles 0..3: ADDR_I = tb*4+c and EN_I = (tb*4+c < T). ADDR_W = mb*4+c and EN_W = (mb*4+c < M).
  - Cycles 1..4: DP_LD = 1, DP_LD_ROW = c-1. DP_ZI/DP_ZW are the registered inverse of the EN_I/EN_W issued in the previous cycle.
- COMP state, N cycles: DP_ACC_EN = 1, DP_K = 0..N-1.
- WRITE state, 4 cycles, r = 0..3:
  - DP_OSEL = r, ADDR_O = {tb*4+r, mb}.
  - EN_O = RW_O = (tb*4+r < T). Rows beyond T consume a cycle without writing.
  - DP_COL_MASK is held valid throughout WRITE.
- After WRITE: advance mb; when mb wraps, advance tb. When the last tile finishes, go to DONE.
- DONE state: DONE = 1 for one cycle, BUSY drops, then IDLE.
- Latency from the START edge to the DONE pulse: nt*nm*(9+N) + 1 cycles. Example: 4,4,4 gives 14.
- EN_I, EN_W and EN_O are never high in IDLE or DONE. ADDR_* values are don't-care whenever the matching enable is low, but must be driven.

Decomposition:
- mac_pkg: TILE, MAXDIM, state enum {IDLE, LOAD, COMP, WRITE, DONE}, field offsets of MNT.
- One sub-module, mac_dim_decode (combinational): MNT -> legal flag, nt, nm, latched N.
- The FSM and the counters stay in the top module.

Test Plan:
- M=N=T=4, START -> 1 tile. LOAD reads addresses 0..3 on both SRAMs. 4 ACC steps with DP_K 0..3. Writes to ADDR_O 0, 2, 4, 6. DONE at cycle 14. ERR=0.
- M=5, N=2, T=3 -> 2 tiles.
  - mb=0: COL_MASK=1111.
  - mb=1: EN_W only on m=4, DP_ZW on rows 1..3, COL_MASK=0001.
  - Writes to ADDR_O 0, 2, 4 (mb=0) and 1, 3, 5 (mb=1). DONE at cycle 2*11+1 = 23.
- M=T=8, N=8 -> 4 tiles in order (tb,mb) = (0,0), (0,1), (1,0), (1,1). Each has 8 COMP cycles, DP_K 0..7. 16 writes covering ADDR_O 0..15 exactly once. DONE at cycle 69.
- MNT = 0x404 (N=0) -> DONE and ERR together 2 cycles after START. No EN_* pulse.
- RSTN low during COMP of the 4,4,4 run -> all outputs 0 asynchronously. A new START after reset produces a clean 14-cycle run.
- Second START pulse mid-run with a different MNT -> ignored. The original schedule and DONE timing are unchanged.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants, FSM state type and MNT field layout for the MAC tile scheduler.
package mac_pkg;

    localparam int TILE   = 4;   // array edge: rows and columns per tile
    localparam int MAXDIM = 8;   // largest legal M, N or T
    localparam int RD_LAT = 1;   // SRAM read latency in cycles
    localparam int DIM_W  = 4;   // width of each MNT field

    // MNT = {M, N, T}
    localparam int MNT_M_LSB = 8;
    localparam int MNT_N_LSB = 4;
    localparam int MNT_T_LSB = 0;

    // LOAD issues TILE reads, the last read lands RD_LAT cycles later
    localparam int LOAD_CYCLES = TILE + RD_LAT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMP,
        S_WRITE,
        S_DONE
    } state_t;

    // A dimension is usable when it is 1..MAXDIM
    function automatic logic dim_legal(input logic [DIM_W-1:0] d);
        return (d != '0) && (d <= DIM_W'(MAXDIM));
    endfunction

endpackage

// File: rtl/mac_tile_scheduler_dim_decode.sv
// Combinational decode of the packed MNT word into dimensions, tile counts and a legality flag.
module mac_dim_decode
    import mac_pkg::*;
(
    input  logic [11:0]      mnt,
    output logic             legal,
    output logic [DIM_W-1:0] m,
    output logic [DIM_W-1:0] n,
    output logic [DIM_W-1:0] t,
    output logic [1:0]       nt,
    output logic [1:0]       nm
);

    // Split fields, check ranges and count tiles (ceil(dim/TILE), 1 or 2 for legal dims)
    always_comb begin
        m     = mnt[MNT_M_LSB +: DIM_W];
        n     = mnt[MNT_N_LSB +: DIM_W];
        t     = mnt[MNT_T_LSB +: DIM_W];
        legal = dim_legal(m) && dim_legal(n) && dim_legal(t);
        nt    = (t > DIM_W'(TILE)) ? 2'd2 : 2'd1;
        nm    = (m > DIM_W'(TILE)) ? 2'd2 : 2'd1;
    end

endmodule

// File: rtl/mac_tile_scheduler.sv
// Sequencer for the 4x4 MAC array: walks output tiles (tb outer, mb inner), issuing
// SRAM reads, accumulate steps and output-row writes. All outputs are registered and
// are computed from the next state so they line up with the state they belong to.
module mac_tile_scheduler
    import mac_pkg::*;
(
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        START,
    input  logic [11:0] MNT,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic        EN_I,
    output logic [2:0]  ADDR_I,
    output logic        EN_W,
    output logic [2:0]  ADDR_W,
    output logic        EN_O,
    output logic        RW_O,
    output logic [3:0]  ADDR_O,
    output logic        DP_CLR,
    output logic        DP_LD,
    output logic [1:0]  DP_LD_ROW,
    output logic        DP_ZI,
    output logic        DP_ZW,
    output logic        DP_ACC_EN,
    output logic [2:0]  DP_K,
    output logic [3:0]  DP_COL_MASK,
    output logic [1:0]  DP_OSEL
);

    logic             dec_legal;
    logic [DIM_W-1:0] dec_m, dec_n, dec_t;
    logic [1:0]       dec_nt, dec_nm;

    mac_dim_decode u_dim_decode (
        .mnt   (MNT),
        .legal (dec_legal),
        .m     (dec_m),
        .n     (dec_n),
        .t     (dec_t),
        .nt    (dec_nt),
        .nm    (dec_nm)
    );

    // Control state
    state_t           state_q, state_d;
    logic [2:0]       c_q, c_d;          // step counter inside LOAD / COMP / WRITE
    logic             tb_q, tb_d;
    logic             mb_q, mb_d;
    logic [DIM_W-1:0] m_q, m_d, n_q, n_d, t_q, t_d;
    logic [1:0]       nt_q, nt_d, nm_q, nm_d;
    logic             err_q, err_d;      // current request was illegal
    logic             pend_q, pend_d;    // illegal request waiting one cycle before reporting

    // Registered outputs
    logic       busy_q, busy_d, done_q, done_d, err_o_q, err_o_d;
    logic       en_i_q, en_i_d, en_w_q, en_w_d, en_o_q, en_o_d, rw_o_q, rw_o_d;
    logic [2:0] addr_i_q, addr_i_d, addr_w_q, addr_w_d;
    logic [3:0] addr_o_q, addr_o_d;
    logic       clr_q, clr_d, ld_q, ld_d, zi_q, zi_d, zw_q, zw_d, acc_q, acc_d;
    logic [1:0] ld_row_q, ld_row_d, osel_q, osel_d;
    logic [2:0] k_q, k_d;
    logic [3:0] col_mask_q, col_mask_d;

    // Per-column "inside M" flags for the next mb
    logic [TILE-1:0] col_hit;
    for (genvar gi = 0; gi < TILE; gi++) begin : g_col
        assign col_hit[gi] = ({1'b0, mb_d, 2'(gi)} < m_d);
    end

    // Next-state logic: request acceptance, phase stepping and tile walk
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        tb_d    = tb_q;
        mb_d    = mb_q;
        m_d     = m_q;
        n_d     = n_q;
        t_d     = t_q;
        nt_d    = nt_q;
        nm_d    = nm_q;
        err_d   = err_q;
        pend_d  = pend_q;
        unique case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    pend_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (START) begin
                    m_d   = dec_m;
                    n_d   = dec_n;
                    t_d   = dec_t;
                    nt_d  = dec_nt;
                    nm_d  = dec_nm;
                    err_d = 1'b0;
                    c_d   = 3'd0;
                    tb_d  = 1'b0;
                    mb_d  = 1'b0;
                    if (dec_legal) begin
                        state_d = S_LOAD;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (c_q == 3'(LOAD_CYCLES - 1)) begin
                    c_d     = 3'd0;
                    state_d = S_COMP;
                end else begin
                    c_d = c_q + 3'd1;
                end
            end
            S_COMP: begin
                if ({1'b0, c_q} == n_q - 4'd1) begin
                    c_d     = 3'd0;
                    state_d = S_WRITE;
                end else begin
                    c_d = c_q + 3'd1;
                end
            end
            S_WRITE: begin
                if (c_q == 3'(TILE - 1)) begin
                    c_d     = 3'd0;
                    state_d = S_LOAD;
                    if ({1'b0, mb_q} == nm_q - 2'd1) begin
                        mb_d = 1'b0;
                        if ({1'b0, tb_q} == nt_q - 2'd1) begin
                            state_d = S_DONE;
                        end else begin
                            tb_d = tb_q + 1'b1;
                        end
                    end else begin
                        mb_d = mb_q + 1'b1;
                    end
                end else begin
                    c_d = c_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so each registered output matches its state
    always_comb begin
        logic [2:0] row;
        logic       rd_phase, ld_phase, wr_phase;
        row      = {tb_d, c_d[1:0]};
        rd_phase = (state_d == S_LOAD) && (c_d < 3'(TILE));
        ld_phase = (state_d == S_LOAD) && (c_d != 3'd0);
        wr_phase = (state_d == S_WRITE);

        busy_d  = (state_d == S_LOAD) || (state_d == S_COMP) || (state_d == S_WRITE) || pend_d;
        done_d  = (state_d == S_DONE);
        err_o_d = (state_d == S_DONE) && err_d;

        en_i_d   = rd_phase && ({1'b0, row} < t_d);
        addr_i_d = rd_phase ? row : 3'd0;
        en_w_d   = rd_phase && ({1'b0, mb_d, c_d[1:0]} < m_d);
        addr_w_d = rd_phase ? {mb_d, c_d[1:0]} : 3'd0;

        clr_d    = (state_d == S_LOAD) && (c_d == 3'd0);
        ld_d     = ld_phase;
        ld_row_d = ld_phase ? 2'(c_d - 3'd1) : 2'd0;
        // Rows whose read was suppressed last cycle are loaded as zeros
        zi_d     = ld_phase && !en_i_q;
        zw_d     = ld_phase && !en_w_q;

        acc_d = (state_d == S_COMP);
        k_d   = (state_d == S_COMP) ? c_d : 3'd0;

        en_o_d     = wr_phase && ({1'b0, row} < t_d);
        rw_o_d     = en_o_d;
        addr_o_d   = wr_phase ? {row, mb_d} : 4'd0;
        osel_d     = wr_phase ? c_d[1:0] : 2'd0;
        col_mask_d = wr_phase ? col_hit : 4'd0;
    end

    // State, counters, latched dimensions and output registers
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= S_IDLE;
            c_q        <= '0;
            tb_q       <= 1'b0;
            mb_q       <= 1'b0;
            m_q        <= '0;
            n_q        <= '0;
            t_q        <= '0;
            nt_q       <= '0;
            nm_q       <= '0;
            err_q      <= 1'b0;
            pend_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_o_q    <= 1'b0;
            en_i_q     <= 1'b0;
            addr_i_q   <= '0;
            en_w_q     <= 1'b0;
            addr_w_q   <= '0;
            en_o_q     <= 1'b0;
            rw_o_q     <= 1'b0;
            addr_o_q   <= '0;
            clr_q      <= 1'b0;
            ld_q       <= 1'b0;
            ld_row_q   <= '0;
            zi_q       <= 1'b0;
            zw_q       <= 1'b0;
            acc_q      <= 1'b0;
            k_q        <= '0;
            col_mask_q <= '0;
            osel_q     <= '0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            tb_q       <= tb_d;
            mb_q       <= mb_d;
            m_q        <= m_d;
            n_q        <= n_d;
            t_q        <= t_d;
            nt_q       <= nt_d;
            nm_q       <= nm_d;
            err_q      <= err_d;
            pend_q     <= pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_o_q    <= err_o_d;
            en_i_q     <= en_i_d;
            addr_i_q   <= addr_i_d;
            en_w_q     <= en_w_d;
            addr_w_q   <= addr_w_d;
            en_o_q     <= en_o_d;
            rw_o_q     <= rw_o_d;
            addr_o_q   <= addr_o_d;
            clr_q      <= clr_d;
            ld_q       <= ld_d;
            ld_row_q   <= ld_row_d;
            zi_q       <= zi_d;
            zw_q       <= zw_d;
            acc_q      <= acc_d;
            k_q        <= k_d;
            col_mask_q <= col_mask_d;
            osel_q     <= osel_d;
        end
    end

    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign ERR         = err_o_q;
    assign EN_I        = en_i_q;
    assign ADDR_I      = addr_i_q;
    assign EN_W        = en_w_q;
    assign ADDR_W      = addr_w_q;
    assign EN_O        = en_o_q;
    assign RW_O        = rw_o_q;
    assign ADDR_O      = addr_o_q;
    assign DP_CLR      = clr_q;
    assign DP_LD       = ld_q;
    assign DP_LD_ROW   = ld_row_q;
    assign DP_ZI       = zi_q;
    assign DP_ZW       = zw_q;
    assign DP_ACC_EN   = acc_q;
    assign DP_K        = k_q;
    assign DP_COL_MASK = col_mask_q;
    assign DP_OSEL     = osel_q;

endmodule

// File: tb/tb_mac_tile_scheduler.sv
// Scoreboard bench for mac_tile_scheduler: stimulus pushes the expected event stream,
// a negedge monitor pops and compares every event the DUT presents.
module tb_mac_tile_scheduler;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        START = 1'b0;
    logic [11:0] MNT = 12'h000;
    logic        BUSY, DONE, ERR, EN_I, EN_W, EN_O, RW_O;
    logic [2:0]  ADDR_I, ADDR_W, DP_K;
    logic [3:0]  ADDR_O, DP_COL_MASK;
    logic        DP_CLR, DP_LD, DP_ZI, DP_ZW, DP_ACC_EN;
    logic [1:0]  DP_LD_ROW, DP_OSEL;

    mac_tile_scheduler dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .MNT(MNT),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .EN_I(EN_I), .ADDR_I(ADDR_I), .EN_W(EN_W), .ADDR_W(ADDR_W),
        .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O),
        .DP_CLR(DP_CLR), .DP_LD(DP_LD), .DP_LD_ROW(DP_LD_ROW),
        .DP_ZI(DP_ZI), .DP_ZW(DP_ZW), .DP_ACC_EN(DP_ACC_EN), .DP_K(DP_K),
        .DP_COL_MASK(DP_COL_MASK), .DP_OSEL(DP_OSEL)
    );

    always #5 CLK = ~CLK;

    logic [32:0] outs;
    assign outs = {BUSY, DONE, ERR, EN_I, ADDR_I, EN_W, ADDR_W, EN_O, RW_O, ADDR_O,
                   DP_CLR, DP_LD, DP_LD_ROW, DP_ZI, DP_ZW, DP_ACC_EN, DP_K,
                   DP_COL_MASK, DP_OSEL};

    localparam int K_RDI = 0, K_RDW = 1, K_CLR = 2, K_LD = 3, K_ACC = 4, K_WR = 5, K_DONE = 6;
    string knames [7] = '{"rd_i", "rd_w", "clr", "ld", "acc", "wr", "done"};

    typedef struct {
        int kind;
        int cyc;
        int a;
        int b;
        int c;
    } ev_t;

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  wr_seen [16];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic push(input int kind, input int at, input int a, input int b, input int c);
        ev_t e;
        e.kind = kind; e.cyc = at; e.a = a; e.b = b; e.c = c;
        sb.push_back(e);
    endtask

    task automatic chk_ev(input int kind, input int a, input int b, input int c);
        ev_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_%s: got cyc=%0d a=%0d b=%0d c=%0d, required no event",
                     knames[kind], cyc, a, b, c);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.a != a || e.b != b || e.c != c) begin
                n_bad++;
                $display("FAIL ev_%s: got %s cyc=%0d a=%0d b=%0d c=%0d, required %s cyc=%0d a=%0d b=%0d c=%0d",
                         knames[e.kind], knames[kind], cyc, a, b, c,
                         knames[e.kind], e.cyc, e.a, e.b, e.c);
            end
        end
    endtask

    // Monitor: one comparison per DUT event, in a fixed per-cycle order
    always @(negedge CLK) begin
        if (RSTN) begin
            if (EN_I)      chk_ev(K_RDI, int'(ADDR_I), 0, 0);
            if (EN_W)      chk_ev(K_RDW, int'(ADDR_W), 0, 0);
            if (DP_CLR)    chk_ev(K_CLR, 0, 0, 0);
            if (DP_LD)     chk_ev(K_LD, int'(DP_LD_ROW), int'({DP_ZI, DP_ZW}), 0);
            if (DP_ACC_EN) chk_ev(K_ACC, int'(DP_K), 0, 0);
            if (EN_O || RW_O) begin
                chk_ev(K_WR, int'(ADDR_O), int'(DP_COL_MASK), int'({DP_OSEL, RW_O}));
                wr_seen[ADDR_O] = wr_seen[ADDR_O] + 1;
            end
            if (DONE)      chk_ev(K_DONE, int'(ERR), int'(BUSY), 0);
            if (EN_I || EN_W || EN_O) begin
                n_cmp++;
                if (!BUSY) begin
                    n_bad++;
                    $display("FAIL busy_with_enable: got BUSY=0 at cyc=%0d, required 1", cyc);
                end
            end
        end
    end

    // Expected event stream of one request whose START is sampled on the edge that begins cycle s
    task automatic push_run(input int m, input int n, input int t, input int done_rel,
                            input int err, input int s);
        int nt, nm, i, base, mask;
        if (err == 0) begin
            nt = (t + 3) / 4;
            nm = (m + 3) / 4;
            i  = 0;
            for (int tb = 0; tb < nt; tb++) begin
                for (int mb = 0; mb < nm; mb++) begin
                    base = s + i * (9 + n);
                    for (int c = 0; c < 5; c++) begin
                        if (c < 4 && tb * 4 + c < t) push(K_RDI, base + c, tb * 4 + c, 0, 0);
                        if (c < 4 && mb * 4 + c < m) push(K_RDW, base + c, mb * 4 + c, 0, 0);
                        if (c == 0) push(K_CLR, base, 0, 0, 0);
                        else push(K_LD, base + c, c - 1,
                                  ((tb * 4 + c - 1 >= t) ? 2 : 0) + ((mb * 4 + c - 1 >= m) ? 1 : 0), 0);
                    end
                    for (int k = 0; k < n; k++) push(K_ACC, base + 5 + k, k, 0, 0);
                    mask = 0;
                    for (int cc = 0; cc < 4; cc++) if (mb * 4 + cc < m) mask = mask | (1 << cc);
                    for (int r = 0; r < 4; r++)
                        if (tb * 4 + r < t) push(K_WR, base + 5 + n + r, (tb * 4 + r) * 2 + mb, mask, r * 2 + 1);
                    i++;
                end
            end
        end
        push(K_DONE, s + done_rel - 1, err, 0, 0);
    endtask

    // Issue START and queue the hand-timed expectations; leaves the bench in cycle s
    task automatic launch(input logic [11:0] mnt, input int done_rel, input int err);
        int s;
        @(negedge CLK);
        MNT   = mnt;
        START = 1'b1;
        s     = cyc + 1;
        push_run(int'(mnt[11:8]), int'(mnt[7:4]), int'(mnt[3:0]), done_rel, err, s);
        @(negedge CLK);
        START = 1'b0;
        n_cmp++;
        if (BUSY !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_after_start mnt=%h: got %b, required 1", mnt, BUSY);
        end
    endtask

    task automatic finish_run(input string name, input int budget);
        int k;
        k = 0;
        while (DONE !== 1'b1 && k < budget) begin
            @(negedge CLK);
            k++;
        end
        if (DONE !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no DONE within %0d cycles, required DONE", name, budget);
        end
        @(negedge CLK);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s_leftover: got %0d unmatched expected events, required 0", name, sb.size());
        end
        sb.delete();
        $display("run %s complete at cyc=%0d", name, cyc);
    endtask

    initial begin
        int k;
        logic saw;
        #12;
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, required 0", outs);
        end
        @(negedge CLK);
        RSTN = 1'b1;

        // 4,4,4: one tile, writes 0,2,4,6, DONE in cycle 14
        launch(12'h444, 14, 0);
        finish_run("m4n4t4", 30);

        // 5,2,3: two tiles along M, DONE in cycle 23
        launch(12'h523, 23, 0);
        finish_run("m5n2t3", 40);

        // 8,8,8: four tiles, every output address written once, DONE in cycle 69
        for (int a = 0; a < 16; a++) wr_seen[a] = 0;
        launch(12'h888, 69, 0);
        finish_run("m8n8t8", 90);
        k = 0;
        for (int a = 0; a < 16; a++) if (wr_seen[a] != 1) k++;
        n_cmp++;
        if (k != 0) begin
            n_bad++;
            $display("FAIL m8n8t8_coverage: got %0d addresses not written exactly once, required 0", k);
        end

        // N=0 is illegal: DONE+ERR in cycle 2, no memory traffic
        launch(12'h404, 2, 1);
        finish_run("illegal_n0", 10);

        // T=9 is illegal as well
        launch(12'h449, 2, 1);
        finish_run("illegal_t9", 10);

        // Asynchronous reset in the middle of COMP
        launch(12'h444, 14, 0);
        saw = 1'b0;
        k = 0;
        while (!saw && k < 20) begin
            @(negedge CLK);
            saw = DP_ACC_EN;
            k++;
        end
        n_cmp++;
        if (!saw) begin
            n_bad++;
            $display("FAIL reach_comp: got no DP_ACC_EN within 20 cycles, required 1");
        end
        @(posedge CLK);
        #2 RSTN = 1'b0;
        #1;
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL async_reset_outputs: got %h, required 0", outs);
        end
        sb.delete();
        @(negedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        launch(12'h444, 14, 0);
        finish_run("after_reset", 30);

        // A second START mid-run must not disturb the schedule
        launch(12'h523, 23, 0);
        repeat (4) @(negedge CLK);
        MNT   = 12'h888;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        MNT   = 12'h000;
        finish_run("restart_ignored", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
